mux_sel_arbiter: RTL and testbench

- Round-robin two-requester arbiter that generates the `sel` input of the downstream 2:1 mux (`din_0`/`din_1` -> `mux_out`).
- Each requester raises a request and receives a one-hot grant.
- While a grant is held, `sel` steers the mux to that requester's data.
- A hold timer bounds grant length so neither source can starve the other.

---
 rtl/mux_sel_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_mux_sel_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_arbiter.sv
// -----------------------------------------------------------------------------
// mux_sel_arbiter
//
// Round-robin arbiter for two requesters sharing a downstream 2:1 mux
// (din_0 / din_1 -> mux_out). The winning requester gets a one-hot grant, and
// `sel` steers the mux to that requester's data for as long as the grant is
// held. A hold timer limits every grant to MAX_HOLD consecutive cycles, so one
// source can never starve the other.
//
// Parameters:
//   MAX_HOLD : maximum consecutive cycles a single grant may be held (2..255).
//   CNT_W    : width of the hold counter; 2**CNT_W must exceed MAX_HOLD.
//
// Ports:
//   clk          : system clock, rising edge.
//   rst          : asynchronous, active-high reset.
//   req_0        : request from source 0 (mux din_0).
//   req_1        : request from source 1 (mux din_1).
//   done         : single-cycle pulse from the consumer; releases the grant.
//   sel          : mux select, 0 = din_0, 1 = din_1. Holds its value in idle.
//   grant_0      : grant to source 0.
//   grant_1      : grant to source 1.
//   busy         : grant_0 | grant_1.
//   switch_count : (MUX_SEL_ARB_STATS_EN only) saturating 16-bit count of
//                  grant moves from one source to the other.
//
// Optional build macro:
//   MUX_SEL_ARB_STATS_EN : adds the switch_count output and its counter.
//
// All outputs are registered. Grants are one-hot or zero.
// -----------------------------------------------------------------------------
module mux_sel_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_0,
  input  logic        req_1,
  input  logic        done,
  output logic        sel,
  output logic        grant_0,
  output logic        grant_1,
  output logic        busy
`ifdef MUX_SEL_ARB_STATS_EN
  ,
  output logic [15:0] switch_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  // Last cycle of a grant: when hold_cnt reaches this value the grant is
  // released on the next edge, giving exactly MAX_HOLD cycles of ownership.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_cnt_nxt;
  // Source that most recently owned the grant; the other one wins a tie.
  logic             last_winner;
  logic             last_winner_nxt;
  // The grant moves to the opposite source on the coming edge.
  logic             switch_evt;

  // Requests seen from the point of view of the current owner.
  logic owner;
  logic own_req;
  logic other_req;
  logic release_now;

  assign owner       = (state == GNT1);
  assign own_req     = owner ? req_1 : req_0;
  assign other_req   = owner ? req_0 : req_1;
  assign release_now = !own_req || done || (hold_cnt == HOLD_LAST);

`ifdef MUX_SEL_ARB_STATS_EN
  // Set once any grant has been issued since reset; the very first grant is
  // not a move "from" another source and is not counted.
  logic owned;
`endif

  // ---------------------------------------------------------------------------
  // Next-state decision
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave
    // it unassigned; otherwise synthesis infers a latch.
    state_nxt       = state;
    hold_cnt_nxt    = hold_cnt;
    last_winner_nxt = last_winner;
    switch_evt      = 1'b0;

    unique case (state)
      IDLE: begin
        hold_cnt_nxt = '0;
        if (req_0 && req_1) begin
          state_nxt = last_winner ? GNT0 : GNT1;
        end else if (req_0) begin
          state_nxt = GNT0;
        end else if (req_1) begin
          state_nxt = GNT1;
        end
        // A grant out of idle to the source that did not own last time is
        // still a move between sources.
`ifdef MUX_SEL_ARB_STATS_EN
        if (state_nxt != IDLE && owned &&
            ((state_nxt == GNT1) != last_winner)) begin
          switch_evt = 1'b1;
        end
`endif
      end

      GNT0, GNT1: begin
        if (!release_now) begin
          hold_cnt_nxt = hold_cnt + CNT_W'(1);
        end else begin
          // done and timeout together are a single release.
          hold_cnt_nxt    = '0;
          last_winner_nxt = owner;
          if (other_req) begin
            // Hand over directly, no idle bubble.
            state_nxt  = owner ? GNT0 : GNT1;
            switch_evt = 1'b1;
          end else if (own_req) begin
            // Re-grant the same source with a fresh hold window.
            state_nxt = state;
          end else begin
            state_nxt = IDLE;
          end
        end
      end

      default: begin
        state_nxt    = IDLE;
        hold_cnt_nxt = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      last_winner <= 1'b1;
      grant_0     <= 1'b0;
      grant_1     <= 1'b0;
      busy        <= 1'b0;
      sel         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state       <= state_nxt;
      hold_cnt    <= hold_cnt_nxt;
      last_winner <= last_winner_nxt;
      grant_0     <= (state_nxt == GNT0);
      grant_1     <= (state_nxt == GNT1);
      busy        <= (state_nxt != IDLE);
      // sel follows the grant and keeps its last value while idle.
      if (state_nxt != IDLE) begin
        sel <= (state_nxt == GNT1);
      end
    end
  end

`ifdef MUX_SEL_ARB_STATS_EN
  // ---------------------------------------------------------------------------
  // Switch statistics
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owned        <= 1'b0;
      switch_count <= '0;
    end else begin
      if (state_nxt != IDLE) begin
        owned <= 1'b1;
      end
      if (switch_evt && (switch_count != 16'hFFFF)) begin
        switch_count <= switch_count + 16'd1;
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_grant_onehot : assert property (@(posedge clk) disable iff (rst)
    !(grant_0 && grant_1));
  a_busy_or : assert property (@(posedge clk) disable iff (rst)
    busy == (grant_0 || grant_1));
  a_sel_tracks : assert property (@(posedge clk) disable iff (rst)
    busy |-> (sel == grant_1));
  a_hold_bound : assert property (@(posedge clk) disable iff (rst)
    hold_cnt <= HOLD_LAST);

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_sel_arbiter
//
// Directed bench for mux_sel_arbiter. A cycle-level model tracks who owns the
// grant, how many cycles it has been held and who owned it last, and every
// clock the DUT outputs are compared against it. Literal expectations at key
// points pin the model to the intended behaviour.
// -----------------------------------------------------------------------------
module tb_mux_sel_arbiter;

  localparam int MAX_HOLD = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_0;
  logic        req_1;
  logic        done;
  logic        sel;
  logic        grant_0;
  logic        grant_1;
  logic        busy;
`ifdef MUX_SEL_ARB_STATS_EN
  logic [15:0] switch_count;
`endif

  mux_sel_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_0   (req_0),
    .req_1   (req_1),
    .done    (done),
    .sel     (sel),
    .grant_0 (grant_0),
    .grant_1 (grant_1),
    .busy    (busy)
`ifdef MUX_SEL_ARB_STATS_EN
    ,
    .switch_count (switch_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: owner is -1 when nobody holds the grant; held counts cycles of
  // ownership including the grant cycle.
  int m_owner;
  int m_held;
  int m_last;
  int m_sel;
  int m_sw;
  bit m_owned;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_last  = 1;
    m_sel   = 0;
    m_sw    = 0;
    m_owned = 1'b0;
  endtask

  task automatic model_step();
    int r[2];
    int n;
    if (rst) begin
      model_reset();
      return;
    end
    r[0] = int'(req_0);
    r[1] = int'(req_1);
    if (m_owner < 0) begin
      n = -1;
      if (r[0] == 1 && r[1] == 1) n = 1 - m_last;
      else if (r[0] == 1)         n = 0;
      else if (r[1] == 1)         n = 1;
      if (n >= 0) begin
        if (m_owned && n != m_last && m_sw < 65535) m_sw++;
        m_owner = n;
        m_held  = 1;
        m_owned = 1'b1;
      end
    end else if (r[m_owner] == 1 && !done && m_held < MAX_HOLD) begin
      m_held++;
    end else begin
      m_last = m_owner;
      if (r[1 - m_owner] == 1) begin
        m_owner = 1 - m_owner;
        m_held  = 1;
        if (m_sw < 65535) m_sw++;
      end else if (r[m_owner] == 1) begin
        m_held = 1;
      end else begin
        m_owner = -1;
      end
    end
    if (m_owner >= 0) m_sel = m_owner;
  endtask

  task automatic compare_all();
    check("grant_0", int'(grant_0), int'(m_owner == 0));
    check("grant_1", int'(grant_1), int'(m_owner == 1));
    check("busy",    int'(busy),    int'(m_owner >= 0));
    check("sel",     int'(sel),     m_sel);
`ifdef MUX_SEL_ARB_STATS_EN
    check("switch_count", int'(switch_count), m_sw);
`endif
  endtask

  // One clock: model advances on the same edge the DUT samples, then the
  // outputs are compared 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    int handovers;
    int busy_drop;
    int gap;
    int hi;
    logic prev_g1;

    rst   = 1'b1;
    req_0 = 1'b0;
    req_1 = 1'b0;
    done  = 1'b0;
    model_reset();

    // Reset for two cycles.
    tick();
    tick();
    check("reset_busy", int'(busy), 0);
    check("reset_sel",  int'(sel), 0);
    rst = 1'b0;

    // First tie goes to source 0.
    req_0 = 1'b1;
    req_1 = 1'b1;
    tick();
    check("tie_grant_0", int'(grant_0), 1);
    check("tie_grant_1", int'(grant_1), 0);
    check("tie_sel",     int'(sel), 0);
    check("tie_busy",    int'(busy), 1);

    // Round-robin: done every 3rd cycle with both requesting.
    handovers = 0;
    busy_drop = 0;
    prev_g1   = grant_1;
    for (int i = 0; i < 15; i++) begin
      done = (i % 3 == 2);
      tick();
      if (grant_1 != prev_g1) handovers++;
      if (!busy) busy_drop = 1;
      prev_g1 = grant_1;
    end
    done = 1'b0;
    check("rr_handovers", handovers, 5);
    check("rr_no_idle",   busy_drop, 0);
    check("rr_end_g1",    int'(grant_1), 1);

    // Single requester held 20 cycles: continuous re-grant.
    req_0 = 1'b0;
    gap   = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!grant_1 || !sel) gap++;
    end
    check("regrant_gap", gap, 0);
    req_1 = 1'b0;
    tick();
    check("drop_grant_1", int'(grant_1), 0);
    check("drop_busy",    int'(busy), 0);
    check("drop_sel",     int'(sel), 1);
`ifdef MUX_SEL_ARB_STATS_EN
    check("stats_switches", int'(switch_count), 5);
`endif

    // Hold timeout: req_0 held, req_1 rises in the grant cycle.
    req_0 = 1'b1;
    tick();
    check("to_grant_0", int'(grant_0), 1);
    req_1 = 1'b1;
    hi    = 1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (grant_0) hi++;
      else break;
    end
    check("to_hold_len", hi, MAX_HOLD);
    check("to_grant_1",  int'(grant_1), 1);
    check("to_sel",      int'(sel), 1);

    // Async reset in the middle of GNT1.
    tick();
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    check("async_grant_1", int'(grant_1), 0);
    check("async_sel",     int'(sel), 0);
    check("async_busy",    int'(busy), 0);
    compare_all();
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_grant_0", int'(grant_0), 1);
    check("post_rst_grant_1", int'(grant_1), 0);

    // Drain back to idle.
    req_0 = 1'b0;
    req_1 = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
